alu_result_stage: RTL and testbench
===================================

ALU_RESULT_STAGE -- requirements
Module: alu_result_stage

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset: clock `clock`, reset `reset_n`.
REQ-002 The block SHALL have parameter RSTATUS_IDX, default 30, the destination register for overflow exception codes.
REQ-003 clock  input  1  rising-edge clock for all state.
REQ-004 reset_n  input  1  synchronous active-low reset.
REQ-005 in_valid  input  1  upstream ALU result valid.
REQ-006 in_ready  output  1  stage can accept; registered.
REQ-007 in_opcode  input  5  instruction opcode field.
REQ-008 in_aluop  input  5  ALU opcode field (0 add, 1 sub).
REQ-009 in_rd  input  5  destination register.
REQ-010 in_result  input  32  ALU data_result.
REQ-011 in_ne, in_lt, in_ovf  input  1 each  ALU isNotEqual, isLessThan, overflow.
REQ-012 flush  input  1  synchronous drop of all buffered entries.
REQ-013 out_valid  output  1  head entry valid.
REQ-014 out_ready  input  1  downstream accepts.
REQ-015 out_data  output  32  writeback value.
REQ-016 out_rd  output  5  writeback register.
REQ-017 out_we  output  1  register write enable.
REQ-018 out_br_taken  output  1  branch resolved taken.
REQ-019 out_exc  output  1  overflow exception was raised.

Function
REQ-020 The block SHALL be a 2-entry FIFO skid buffer: push on in_valid&&in_ready, pop on out_valid&&out_ready, with 1-cycle latency from push to out_valid.
REQ-021 in_ready SHALL be a register that equals 1 when the next-cycle occupancy is less than 2.
REQ-022 Simultaneous push and pop SHALL keep occupancy unchanged, and a pop at occupancy 2 SHALL let in_ready rise the following cycle.
REQ-023 out_valid SHALL equal (occupancy>0), and outputs SHALL be driven from the head entry and held stable while out_valid&&!out_ready.
REQ-024 Decoding at push time SHALL work as follows.
- R-type (opcode 00000) with aluop 0 or 1, and addi (00101): out_we=1, out_data=in_result, out_rd=in_rd.
- bne (00010): out_we=0, out_br_taken=in_ne.
- blt (00110): out_we=0, out_br_taken=in_lt.
- All other opcodes: out_we=1, out_br_taken=0.
REQ-025 When in_ovf=1 and the instruction is add, addi or sub, the stage SHALL write out_rd=RSTATUS_IDX and out_data=1, 2 or 3 respectively, with out_exc=1.
REQ-026 in_ovf SHALL be ignored for all other instructions.
REQ-027 A push of in_rd=0 with out_exc=0 SHALL force out_we=0.
REQ-028 flush SHALL set occupancy to 0 and in_ready to 1 next cycle, SHALL win over a same-cycle push or pop, and SHALL NOT produce a pop.
REQ-029 Occupancy pointers SHALL wrap modulo 2.

Reset
REQ-030 While reset_n=0 at a clock edge, the stage SHALL set occupancy to 0, out_valid to 0, and in_ready to 1.
REQ-031 Reset SHALL set all stored entry fields to 0 (out_data=0, out_rd=0, out_we=0, out_br_taken=0, out_exc=0).
REQ-032 Reset asserted mid-stream SHALL discard both entries without a pop.
REQ-033 Reset SHALL take priority over flush and over handshakes.

Configuration
REQ-034 With macro ALU_RESULT_STAGE_EXC_EN defined, the overflow rewrite of REQ-025 SHALL be present.
REQ-035 Without ALU_RESULT_STAGE_EXC_EN, in_ovf SHALL be ignored, out_exc SHALL be tied to 0, and out_data/out_rd SHALL always carry in_result/in_rd.

Structure
REQ-036 Shared package alu_stage_pkg SHALL hold opcode constants (OP_RTYPE, OP_ADDI, OP_BNE, OP_BLT), ALU op constants (ALU_ADD, ALU_SUB), exception codes (EXC_ADD=1, EXC_ADDI=2, EXC_SUB=3), and the entry struct typedef.
REQ-037 Decoding SHALL be combinational at the input, and storage SHALL be in one sub-module, stage_skid_buf, parameterised by entry width.

Verification
REQ-038 Add overflow: opcode 0, aluop 0, rd 5, result 0x80000000, ovf=1 -> one cycle later out_valid=1, out_rd=30, out_data=1, out_we=1, out_exc=1.
REQ-039 bne: opcode 00010, ne=1 -> out_br_taken=1, out_we=0; the same with ne=0 -> out_br_taken=0.
REQ-040 Backpressure: out_ready=0 with 3 back-to-back pushes (results 10, 20, 30) -> in_ready=0 after the 2nd push, the 3rd push is held, and draining yields 10, 20, 30 in order.
REQ-041 Simultaneous push and pop at occupancy 1 for 8 cycles -> in_ready stays 1 and no entry is lost or duplicated.
REQ-042 flush with occupancy 2 and in_valid=1 -> next cycle out_valid=0, in_ready=1, and the flushed input does not appear.
REQ-043 reset_n=0 mid-stream -> out_valid=0, in_ready=1, out_data=0; with ALU_RESULT_STAGE_EXC_EN undefined, the first scenario's stimulus yields out_rd=5, out_data=0x80000000, out_exc=0.

Source files
------------

// File: rtl/alu_stage_pkg.sv
// alu_stage_pkg: opcode, ALU op and exception constants plus the buffered entry layout
package alu_stage_pkg;
  localparam logic [4:0] OP_RTYPE = 5'b00000;
  localparam logic [4:0] OP_ADDI = 5'b00101;
  localparam logic [4:0] OP_BNE = 5'b00010;
  localparam logic [4:0] OP_BLT = 5'b00110;
  localparam logic [4:0] ALU_ADD = 5'd0;
  localparam logic [4:0] ALU_SUB = 5'd1;
  localparam logic [31:0] EXC_ADD = 32'd1;
  localparam logic [31:0] EXC_ADDI = 32'd2;
  localparam logic [31:0] EXC_SUB = 32'd3;
  typedef struct packed {
    logic [31:0] data;
    logic [4:0] rd;
    logic we;
    logic br_taken;
    logic exc;
  } entry_t;
  localparam int ENTRY_W = $bits(entry_t);
endpackage

// File: rtl/alu_result_stage_skid_buf.sv
// stage_skid_buf: 2-entry FIFO skid buffer with registered in_ready and synchronous flush
module stage_skid_buf #(
  parameter int W = 40
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);
  logic [W-1:0] mem_q [2];
  logic [W-1:0] mem_d [2];
  logic wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [1:0] count_q, count_d;
  logic in_ready_q, in_ready_d;
  logic push, pop;
  always_comb begin
    push = in_valid && in_ready_q;
    pop = count_q != 2'd0 && out_ready;
    mem_d = mem_q;
    if (push && !flush) mem_d[wr_ptr_q] = in_data;
    wr_ptr_d = flush ? 1'b0 : wr_ptr_q ^ push;
    rd_ptr_d = flush ? 1'b0 : rd_ptr_q ^ pop;
    count_d = flush ? 2'd0 : count_q + 2'(push) - 2'(pop);
    in_ready_d = count_d < 2'd2;
  end
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q <= 2'd0;
      in_ready_q <= 1'b1;
    end else begin
      mem_q <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q <= count_d;
      in_ready_q <= in_ready_d;
    end
  end
  assign in_ready = in_ready_q;
  assign out_valid = count_q != 2'd0;
  assign out_data = mem_q[rd_ptr_q];
endmodule

// File: rtl/alu_result_stage.sv
// alu_result_stage: decodes ALU results into a 2-entry skid buffer; ALU_RESULT_STAGE_EXC_EN adds overflow rewrite
module alu_result_stage
  import alu_stage_pkg::*;
#(
  parameter int RSTATUS_IDX = 30
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [4:0]  in_opcode,
  input  logic [4:0]  in_aluop,
  input  logic [4:0]  in_rd,
  input  logic [31:0] in_result,
  input  logic        in_ne,
  input  logic        in_lt,
  input  logic        in_ovf,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [4:0]  out_rd,
  output logic        out_we,
  output logic        out_br_taken,
  output logic        out_exc
);
  entry_t ent, head;
  logic is_bne, is_blt;
`ifdef ALU_RESULT_STAGE_EXC_EN
  logic is_add, is_sub, is_addi, raise;
  assign is_add = in_opcode == OP_RTYPE && in_aluop == ALU_ADD;
  assign is_sub = in_opcode == OP_RTYPE && in_aluop == ALU_SUB;
  assign is_addi = in_opcode == OP_ADDI;
  assign raise = in_ovf && (is_add || is_addi || is_sub);
`else
  logic [10:0] unused_cfg;
  assign unused_cfg = {in_ovf, in_aluop, 5'(RSTATUS_IDX)};
`endif
  always_comb begin
    is_bne = in_opcode == OP_BNE;
    is_blt = in_opcode == OP_BLT;
    ent.data = in_result;
    ent.rd = in_rd;
    ent.exc = 1'b0;
    ent.br_taken = is_bne ? in_ne : is_blt ? in_lt : 1'b0;
    ent.we = !(is_bne || is_blt);
`ifdef ALU_RESULT_STAGE_EXC_EN
    if (raise) begin
      ent.data = is_add ? EXC_ADD : is_addi ? EXC_ADDI : EXC_SUB;
      ent.rd = 5'(RSTATUS_IDX);
      ent.exc = 1'b1;
      ent.we = 1'b1;
    end
`endif
    if (in_rd == 5'd0 && !ent.exc) ent.we = 1'b0;
  end
  stage_skid_buf #(.W(ENTRY_W)) u_buf (
    .clock(clock),
    .reset_n(reset_n),
    .flush(flush),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(ent),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(head)
  );
  assign out_data = head.data;
  assign out_rd = head.rd;
  assign out_we = head.we;
  assign out_br_taken = head.br_taken;
  assign out_exc = head.exc;
endmodule

// File: tb/tb_alu_result_stage.sv
// tb_alu_result_stage: randomized scoreboard bench with directed handshake, flush and reset scenarios
module tb_alu_result_stage;
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic in_valid = 1'b0, flush = 1'b0, out_ready = 1'b0;
  logic in_ne = 1'b0, in_lt = 1'b0, in_ovf = 1'b0;
  logic [4:0] in_opcode = '0, in_aluop = '0, in_rd = '0;
  logic [31:0] in_result = '0;
  logic in_ready, out_valid, out_we, out_br_taken, out_exc;
  logic [31:0] out_data;
  logic [4:0] out_rd;
  typedef struct packed {
    logic [31:0] d;
    logic [4:0] r;
    logic we, br, exc;
  } exp_t;
  exp_t q[$];
  int checks = 0, failures = 0;
  bit armed = 1'b0;
`ifdef ALU_RESULT_STAGE_EXC_EN
  localparam bit EXC = 1'b1;
`else
  localparam bit EXC = 1'b0;
`endif
  always #5 clock = ~clock;
  alu_result_stage dut (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_aluop(in_aluop), .in_rd(in_rd), .in_result(in_result),
    .in_ne(in_ne), .in_lt(in_lt), .in_ovf(in_ovf), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_rd(out_rd),
    .out_we(out_we), .out_br_taken(out_br_taken), .out_exc(out_exc)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  // Reference decode written straight from the instruction semantics
  function automatic exp_t model(input logic [4:0] op, input logic [4:0] alu, input logic [4:0] rd,
                                 input logic [31:0] res, input logic ne, input logic lt, input logic ovf);
    exp_t e;
    int code;
    e = '{d: res, r: rd, we: 1'b1, br: 1'b0, exc: 1'b0};
    if (op == 5'b00010) begin e.we = 1'b0; e.br = ne; end
    else if (op == 5'b00110) begin e.we = 1'b0; e.br = lt; end
    code = (op == 5'd0 && alu == 5'd0) ? 1 : (op == 5'b00101) ? 2 : (op == 5'd0 && alu == 5'd1) ? 3 : 0;
    if (EXC && ovf && code != 0) begin e.d = 32'(code); e.r = 5'd30; e.exc = 1'b1; end
    if (rd == 5'd0 && !e.exc) e.we = 1'b0;
    return e;
  endfunction
  always @(negedge clock) begin
    if (armed) begin
      chk("in_ready", 32'(in_ready), 32'(q.size() < 2));
      chk("out_valid", 32'(out_valid), 32'(q.size() > 0));
      if (out_valid && q.size() > 0) begin
        chk("sb_data", out_data, q[0].d);
        chk("sb_rd", 32'(out_rd), 32'(q[0].r));
        chk("sb_we", 32'(out_we), 32'(q[0].we));
        chk("sb_br", 32'(out_br_taken), 32'(q[0].br));
        chk("sb_exc", 32'(out_exc), 32'(q[0].exc));
      end
    end
    if (!reset_n) begin
      q.delete();
      armed = 1'b1;
    end else if (flush) q.delete();
    else begin
      if (out_valid && out_ready && q.size() > 0) void'(q.pop_front());
      if (in_valid && in_ready) q.push_back(model(in_opcode, in_aluop, in_rd, in_result, in_ne, in_lt, in_ovf));
    end
  end
  task automatic tick();
    @(posedge clock);
    #1;
  endtask
  task automatic push_set(input logic [4:0] op, input logic [4:0] alu, input logic [4:0] rd,
                          input logic [31:0] res, input logic ne, input logic lt, input logic ovf);
    in_valid = 1'b1;
    in_opcode = op; in_aluop = alu; in_rd = rd; in_result = res;
    in_ne = ne; in_lt = lt; in_ovf = ovf;
  endtask
  task automatic push_rand();
    logic [4:0] op;
    case ($urandom_range(0, 4))
      0: op = 5'b00000;
      1: op = 5'b00101;
      2: op = 5'b00010;
      3: op = 5'b00110;
      default: op = 5'($urandom_range(0, 31));
    endcase
    push_set(op, ($urandom_range(0, 2) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 1)),
             ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31)), $urandom,
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
  endtask
  initial begin
    repeat (2) tick();
    reset_n = 1'b1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_data", out_data, 32'd0);
    chk("rst_rd", 32'(out_rd), 32'd0);
    chk("rst_flags", 32'({out_we, out_br_taken, out_exc}), 32'd0);
    push_set(5'd0, 5'd0, 5'd5, 32'h8000_0000, 1'b0, 1'b0, 1'b1);
    tick();
    in_valid = 1'b0;
    chk("ovf_valid", 32'(out_valid), 32'd1);
    chk("ovf_rd", 32'(out_rd), EXC ? 32'd30 : 32'd5);
    chk("ovf_data", out_data, EXC ? 32'd1 : 32'h8000_0000);
    chk("ovf_we", 32'(out_we), 32'd1);
    chk("ovf_exc", 32'(out_exc), EXC ? 32'd1 : 32'd0);
    out_ready = 1'b1;
    tick();
    push_set(5'b00010, 5'd0, 5'd7, 32'd55, 1'b1, 1'b0, 1'b0);
    tick();
    chk("bne_taken", 32'(out_br_taken), 32'd1);
    chk("bne_we", 32'(out_we), 32'd0);
    push_set(5'b00010, 5'd0, 5'd7, 32'd66, 1'b0, 1'b1, 1'b0);
    tick();
    chk("bne_not_taken", 32'(out_br_taken), 32'd0);
    in_valid = 1'b0;
    tick();
    out_ready = 1'b0;
    push_set(5'b00101, 5'd0, 5'd3, 32'd10, 1'b0, 1'b0, 1'b0);
    tick();
    chk("bp_ready1", 32'(in_ready), 32'd1);
    in_result = 32'd20;
    tick();
    chk("bp_ready2", 32'(in_ready), 32'd0);
    in_result = 32'd30;
    tick();
    chk("bp_held", 32'(in_ready), 32'd0);
    chk("bp_head", out_data, 32'd10);
    out_ready = 1'b1;
    tick();
    chk("bp_rise", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    repeat (3) tick();
    out_ready = 1'b0;
    push_rand();
    tick();
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      push_rand();
      tick();
      chk("stream_ready", 32'(in_ready), 32'd1);
    end
    in_valid = 1'b0;
    tick();
    out_ready = 1'b0;
    push_set(5'b00101, 5'd0, 5'd4, 32'd100, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    in_result = 32'd300;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("flush_valid", 32'(out_valid), 32'd0);
    chk("flush_ready", 32'(in_ready), 32'd1);
    push_set(5'b00101, 5'd0, 5'd4, 32'd400, 1'b0, 1'b0, 1'b0);
    tick();
    in_result = 32'd500;
    out_ready = 1'b1;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    tick();
    chk("flush_push_dropped", 32'(out_valid), 32'd0);
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 9) < 7) push_rand(); else in_valid = 1'b0;
      out_ready = $urandom_range(0, 9) < 6;
      flush = $urandom_range(0, 29) == 0;
      tick();
    end
    flush = 1'b0;
    out_ready = 1'b0;
    push_rand();
    tick();
    push_rand();
    tick();
    reset_n = 1'b0;
    in_valid = 1'b0;
    tick();
    reset_n = 1'b1;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_ready", 32'(in_ready), 32'd1);
    chk("mid_rst_data", out_data, 32'd0);
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      push_rand();
      tick();
    end
    in_valid = 1'b0;
    repeat (4) tick();
    chk("drain_empty", 32'(q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
